// File: rtl/bus_slice_arbiter.sv
// bus_slice_arbiter: round-robin burst arbiter sharing one signed-index bus between NREQ producers
module bus_slice_arbiter #(
    parameter int NREQ      = 2,
    parameter int WIDTH     = 5,
    parameter int LSB       = -2,
    parameter int MAX_BURST = 4,
    localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         last,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    output logic [OW-1:0]           owner,
    output logic                    bus_valid,
    output logic [WIDTH-1+LSB:LSB]  bus_data
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t                   state_q, state_d;
    logic [NREQ-1:0]          gnt_q, gnt_d;
    logic [OW-1:0]            owner_q, owner_d;
    logic [OW-1:0]            ptr_q, ptr_d;
    logic [BW-1:0]            cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic [WIDTH-1+LSB:LSB]   data_q, data_d;

    logic                     found;
    logic [OW-1:0]            pick;
    logic                     accept;
    logic                     rel;
    logic [WIDTH-1:0]         slice;

    assign slice  = data_in[int'(owner_q)*WIDTH +: WIDTH];
    assign accept = (state_q == GRANT) && req[owner_q];
    assign rel    = last[owner_q] || (cnt_q == BW'(MAX_BURST - 1));

    // Round-robin pick: first asserted request scanning from ptr upward, wrapping at NREQ
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                pick  = OW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    // Next-state: grant from IDLE, accept/release beats in GRANT, advance ptr in TURN
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << pick;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    valid_d = 1'b1;
                    data_d  = slice;
                    cnt_d   = cnt_q + 1'b1;
                end
                if (!accept || rel) begin
                    state_d = TURN;
                    gnt_d   = '0;
                end
            end
            TURN: begin
                ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign bus_valid = valid_q;
    assign bus_data  = data_q;

endmodule

// File: tb/tb_bus_slice_arbiter.sv
// tb_bus_slice_arbiter: directed-vector bench for the round-robin bus slice arbiter
module tb_bus_slice_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  last;
    logic [9:0]  data_in;
    logic [1:0]  gnt;
    logic        owner;
    logic        bus_valid;
    logic [2:-2] bus_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] g2 [6]  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    logic       v2 [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] d2 [6]  = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd5, 5'd5};

    logic [1:0] g3 [14] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10,
                            2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    logic       v3 [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] d3 [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd4,
                            5'd23, 5'd24, 5'd25, 5'd26, 5'd26, 5'd26, 5'd13};
    logic       o3 [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    logic [1:0] g4 [7]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    logic       v4 [7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] d4 [7]  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd4};

    logic [1:0] g5 [7]  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};
    logic       v5 [7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0] d5 [7]  = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd22};
    logic       o5 [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    bus_slice_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .gnt       (gnt),
        .owner     (owner),
        .bus_valid (bus_valid),
        .bus_data  (bus_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input int c, input logic [1:0] r, input logic [1:0] l,
                       input logic [1:0] eg, input logic ev, input logic [4:0] ed, input logic eo);
        req     = r;
        last    = l;
        data_in = {5'(16 + c), 5'(c)};
        tick;
        check($sformatf("%s c%0d gnt", tag, c), 32'(gnt), 32'(eg));
        check($sformatf("%s c%0d valid", tag, c), 32'(bus_valid), 32'(ev));
        check($sformatf("%s c%0d data", tag, c), 32'(bus_data), 32'(ed));
        check($sformatf("%s c%0d owner", tag, c), 32'(owner), 32'(eo));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = 2'b00;
        last  = 2'b00;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 2'b11;
        last    = 2'b00;
        data_in = 10'h2B5;
        for (int i = 0; i < 2; i++) begin
            tick;
            check($sformatf("t1 rst%0d gnt", i), 32'(gnt), 32'h0);
            check($sformatf("t1 rst%0d valid", i), 32'(bus_valid), 32'h0);
            check($sformatf("t1 rst%0d data", i), 32'(bus_data), 32'h0);
            check($sformatf("t1 rst%0d owner", i), 32'(owner), 32'h0);
        end
        rst_n = 1'b1;
        tick;
        check("t1 first gnt", 32'(gnt), 32'h1);
        check("t1 first valid", 32'(bus_valid), 32'h0);
        req = 2'b00;
        tick;
        check("t1 abandon gnt", 32'(gnt), 32'h0);
        check("t1 abandon valid", 32'(bus_valid), 32'h0);

        do_reset;
        for (int i = 0; i < 6; i++)
            cyc("t2", i + 2, 2'b01, (i == 3) ? 2'b01 : 2'b00, g2[i], v2[i], d2[i], 1'b0);

        do_reset;
        for (int c = 0; c < 14; c++)
            cyc("t3", c, 2'b11, 2'b00, g3[c], v3[c], d3[c], o3[c]);

        do_reset;
        for (int c = 0; c < 7; c++)
            cyc("t4", c, 2'b01, (c == 4) ? 2'b01 : 2'b00, g4[c], v4[c], d4[c], 1'b0);

        do_reset;
        for (int c = 0; c < 7; c++)
            cyc("t5", c, (c < 3) ? 2'b11 : 2'b10, 2'b00, g5[c], v5[c], d5[c], o5[c]);

        rst_n = 1'b0;
        req   = 2'b11;
        tick;
        check("t6 rst gnt", 32'(gnt), 32'h0);
        check("t6 rst valid", 32'(bus_valid), 32'h0);
        check("t6 rst data", 32'(bus_data), 32'h0);
        check("t6 rst owner", 32'(owner), 32'h0);
        rst_n = 1'b1;
        tick;
        check("t6 regrant gnt", 32'(gnt), 32'h1);
        check("t6 regrant owner", 32'(owner), 32'h0);
        check("t6 regrant valid", 32'(bus_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
